rr_mux4to1: RTL
===============

# rr_mux4to1

Four-channel round-robin merging multiplexer: the gathering counterpart of the team's `demux1to4` fan-out.
- Accepts up to four independent valid/ready word streams and serialises them onto one registered output stream.
- Tags each output word with its 2-bit source index, so a downstream `demux1to4` can route responses back using that index as its {a,b} select.
- Sits between per-lane producers and a single shared consumer, such as a shared bus port or a single FIFO.

## Interface
- `WIDTH`, default 8: data word width per channel.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 4: per-channel word-present flag; bit i is channel i.
- `in_data` in 4*WIDTH: packed words; channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready` out 4: per-channel accept; a transfer occurs on channel i when `in_valid[i] & in_ready[i]` at a rising edge.
- `out_valid` out 1: output register holds a word.
- `out_data` out WIDTH: registered word.
- `out_sel` out 2: source channel index of `out_data`; bit1 maps to `a`, bit0 maps to `b`.
- `out_ready` in 1: consumer accept; an output transfer occurs when `out_valid & out_ready`.

## Operation
- **Load enable.** `load = ~out_valid | out_ready`, i.e. the output register is empty or is being drained this cycle.
- **Round-robin pointer.** `ptr` is 2 bits and resets to 0. Priority order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- **Grant.** Combinational. `grant` is one-hot, naming the first channel in priority order with `in_valid` set. It is zero when no channel is valid.
- **Accept.** `in_ready = grant & {4{load}}`. At most one `in_ready` bit is high in any cycle. `in_ready` never depends on `in_valid` of a non-granted channel.
- **On a cycle with `load` and a grant to channel g:**
  - `out_data` <= channel g word.
  - `out_sel` <= g.
  - `out_valid` <= 1.
  - `ptr` <= g+1 (mod 4; 3 wraps to 0).
- **On a cycle with `load` and no grant:** `out_valid` <= 0. `out_data`, `out_sel` and `ptr` hold.
- **On a cycle with `~load`:** the stall holds `out_valid`, `out_data`, `out_sel` and `ptr` unchanged. `in_ready` stays 0.
- **Pointer advance.** `ptr` advances only on an accepted input, never on idle cycles.
- **Stability.** Once `out_valid` is high, `out_data` and `out_sel` stay stable until the output transfer completes.
- **Dropped requests.** An input that drops `in_valid` before it is granted is simply skipped. No state is retained for it.

## Timing
- **Reset.** While `rst_n` is low, all of the following hold: `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0, `in_ready` = 0.
  - `in_ready` is gated by an internal registered "out of reset" flag, which sets on the first `clk` edge after `rst_n` rises.
- **Reset mid-operation.** Any word held in the output register is discarded. No partial transfer survives.
- **Latency.** Input accept at edge N gives `out_valid` high from edge N onward, i.e. visible in cycle N+1.
- **Throughput.** With `out_ready` held high, one word per clock, with no bubble between back-to-back words.
- **Drain and refill.** An output transfer and an input accept may happen at the same edge; the register is reloaded at that edge.
- **Fairness.** With all four channels continuously valid and the output never stalled, grants follow 0,1,2,3,0,… Each channel is served exactly once in every window of 4 transfers.

## Configuration
- `RR_MUX4_FIXED_PRIO_EN`
  - **Defined:** the pointer logic is compiled out and priority is fixed at channel 0 > 1 > 2 > 3. Grant is the lowest-index valid channel. All other behaviour is unchanged: handshake, latency, and `out_sel` tagging.
  - **Undefined (default):** round-robin as specified above.

## Test plan
- **Reset values.** Drive `rst_n` = 0 with all `in_valid` = 4'hF. Expect `in_ready` = 0, `out_valid` = 0, `out_data` = 0 and `out_sel` = 0 throughout, and for the first edge after release.
- **Single channel.** `in_valid` = 4'b0100 with channel 2 data 8'hA5, `out_ready` = 1. Expect `in_ready` = 4'b0100 for one cycle, then `out_valid` = 1, `out_data` = 8'hA5, `out_sel` = 2'b10.
- **Full fairness.** `in_valid` = 4'hF held with data 8'h10/8'h11/8'h12/8'h13 and `out_ready` = 1. Expect `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles with no gaps.
- **Backpressure.** Start as in full fairness, then drive `out_ready` = 0 for 3 cycles after the first word. Expect `out_data` to hold 8'h10 with `out_sel` = 0 and `in_ready` = 0 during the stall. After release the sequence resumes with `out_sel` = 1, with nothing lost and nothing duplicated.
- **Pointer wrap and skip.** `in_valid` = 4'b1001 continuously. Expect `out_sel` alternating 3,0,3,0… after the first grant to 0. With `RR_MUX4_FIXED_PRIO_EN` defined, expect `out_sel` = 0 every cycle.
- **Reset mid-stream.** Assert `rst_n` low while `out_valid` = 1 and `out_ready` = 0. Expect `out_valid` to drop to 0 immediately, without waiting for a clock. After release, the first grant goes to channel 0.

Source files
------------

// File: rtl/rr_mux4to1_if.sv
// rtl/rr_mux4to1_if.sv - handshake bundle for the four-lane round-robin merge (lanes in, tagged stream out)
interface rr_mux4to1_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  // Producer/consumer side: drives lane words and output acceptance.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  // Multiplexer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux4to1.sv
// rtl/rr_mux4to1.sv - four-lane round-robin merge onto one registered, source-tagged stream (RR_MUX4_FIXED_PRIO_EN selects fixed 0>1>2>3 priority)
module rr_mux4to1 #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_mux4to1_if.slave   bus
);

  logic             alive;
  logic             load;
  logic             take;
  logic [3:0]       grant;
  logic [1:0]       grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] grant_data;

  // Output register may be written when empty or being drained this cycle.
  assign load = ~bus.out_valid | bus.out_ready;
  assign take = alive & load & grant_any;

  // Accept is held off until the first edge after reset release.
  assign bus.in_ready = grant & {4{load & alive}};

  // Marks the design as out of reset one edge after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

`ifdef RR_MUX4_FIXED_PRIO_EN
  // Fixed priority: lowest-index valid lane wins.
  always_comb begin
    grant     = 4'b0000;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!grant_any && bus.in_valid[k]) begin
        grant[k]  = 1'b1;
        grant_idx = 2'(k);
        grant_any = 1'b1;
      end
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] idx;

  // Round-robin: scan from ptr upward, wrapping mod 4.
  always_comb begin
    grant     = 4'b0000;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    idx       = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!grant_any && bus.in_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

  // Pointer moves past the served lane only when a word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (take) begin
      ptr <= grant_idx + 2'd1;
    end
  end
`endif

  // Selects the granted lane's word from the packed input bus.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant_idx == 2'(k)) begin
        grant_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on accept, empty on an idle load cycle, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= 2'd0;
    end else if (alive && load) begin
      if (grant_any) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= grant_data;
        bus.out_sel   <= grant_idx;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
